// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between requester A (logger) and
// requester B (readback) with round-robin arbitration. Each transaction pulses
// SRAM_CMD for one cycle, follows the controller busy flag through its rise and
// fall, then acknowledges the owner for one cycle.
// Optional feature: define SRAM_ARB_WATCHDOG_EN to add a wait-state timeout that
// pulses ERR and force-completes the transaction after TIMEOUT_CYCLES.
module sram_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic              REQ_A,
    input  logic              WE_A,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [DATA_W-1:0] WDATA_A,
    input  logic              BANK_A,
    output logic              ACK_A,
    output logic [DATA_W-1:0] RDATA_A,
    input  logic              REQ_B,
    input  logic              WE_B,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] WDATA_B,
    input  logic              BANK_B,
    output logic              ACK_B,
    output logic [DATA_W-1:0] RDATA_B,
    output logic [1:0]        SRAM_CMD,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_WDATA,
    output logic              SRAM_BANK,
    input  logic              SRAM_STATUS,
    input  logic [DATA_W-1:0] SRAM_RDATA,
    output logic              ARB_BUSY,
    output logic              GNT_B,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_grant;
    logic              w_grant_b;
    logic              w_sel_we;
    logic              w_capture;
    logic              w_timeout;
    logic              w_wd_hit;

    logic [1:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_bank;
    logic              r_we;
    logic              r_gnt_b;
    logic              r_ack_a;
    logic              r_ack_b;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    // r_gnt_b doubles as last_grant: it always names the most recent owner.
    assign w_sel_we = w_grant_b ? WE_B : WE_A;

    // State register
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus grant, read-capture and timeout decisions
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_b = r_gnt_b;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    w_grant   = 1'b1;
                    // On contention the requester that did not win last time goes first.
                    w_grant_b = REQ_B && (!REQ_A || !r_gnt_b);
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (SRAM_STATUS) begin
                    w_next = S_WAIT_DONE;
                end else if (w_wd_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_COMPLETE;
                end
            end
            S_WAIT_DONE: begin
                // A genuine busy drop wins over a timeout landing on the same edge.
                if (!SRAM_STATUS) begin
                    w_capture = !r_we;
                    w_next    = S_COMPLETE;
                end else if (w_wd_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs: command/address latch, acknowledges, read data, busy flag
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            r_cmd     <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bank    <= 1'b0;
            r_we      <= 1'b0;
            r_gnt_b   <= 1'b1;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (w_grant) begin
                r_addr  <= w_grant_b ? ADDR_B : ADDR_A;
                r_wdata <= w_grant_b ? WDATA_B : WDATA_A;
                r_bank  <= w_grant_b ? BANK_B : BANK_A;
                r_we    <= w_sel_we;
                r_cmd   <= w_sel_we ? 2'd2 : 2'd1;
                r_gnt_b <= w_grant_b;
            end else begin
                // Grants only happen from IDLE, so CMD is non-zero for ISSUE alone.
                r_cmd <= 2'd0;
            end
            r_ack_a <= (w_next == S_COMPLETE) && !r_gnt_b;
            r_ack_b <= (w_next == S_COMPLETE) && r_gnt_b;
            r_busy  <= (w_next != S_IDLE);
            if (w_capture && !r_gnt_b) begin
                r_rdata_a <= SRAM_RDATA;
            end
            if (w_capture && r_gnt_b) begin
                r_rdata_b <= SRAM_RDATA;
            end
        end
    end

`ifdef SRAM_ARB_WATCHDOG_EN
    localparam logic [3:0] WD_LIMIT = 4'(TIMEOUT_CYCLES - 1);

    logic [3:0] r_wd_cnt;
    logic       r_err;

    // Watchdog counter: cleared on the way into WAIT_BUSY, saturates while waiting
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            r_wd_cnt <= 4'd0;
        end else if (r_state == S_ISSUE) begin
            r_wd_cnt <= 4'd0;
        end else if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && (r_wd_cnt != 4'hF)) begin
            r_wd_cnt <= r_wd_cnt + 4'd1;
        end
    end

    // The count reaches TIMEOUT_CYCLES-1 after that many wait cycles; the next edge fires.
    assign w_wd_hit = (r_wd_cnt >= WD_LIMIT);

    // One-cycle ERR pulse alongside the forced completion
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign ERR = r_err;
`else
    logic w_unused_timeout;

    // Without the watchdog the wait states never give up.
    assign w_wd_hit         = 1'b0;
    assign ERR              = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0) ^ w_timeout;
`endif

    assign SRAM_CMD   = r_cmd;
    assign SRAM_ADDR  = r_addr;
    assign SRAM_WDATA = r_wdata;
    assign SRAM_BANK  = r_bank;
    assign ACK_A      = r_ack_a;
    assign ACK_B      = r_ack_b;
    assign RDATA_A    = r_rdata_a;
    assign RDATA_B    = r_rdata_b;
    assign ARB_BUSY   = r_busy;
    assign GNT_B      = r_gnt_b;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: bench for sram_arbiter with a nominal SRAM controller model
// (busy one cycle for writes, two for reads, starting one cycle after CMD) and a
// transaction-level reference model that predicts every output each cycle.
module tb_sram_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int TIMEOUT_CYCLES = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_a = 1'b0, we_a = 1'b0, bank_a = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0;
    logic [DATA_W-1:0] wdata_a = '0;
    logic              req_b = 1'b0, we_b = 1'b0, bank_b = 1'b0;
    logic [ADDR_W-1:0] addr_b = '0;
    logic [DATA_W-1:0] wdata_b = '0;
    logic              ack_a, ack_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [1:0]        sram_cmd;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_bank;
    logic              sram_status = 1'b0;
    logic [DATA_W-1:0] sram_rdata = '0;
    logic              arb_busy, gnt_b, err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    bit m_en = 1'b1;
    bit ctl_stuck = 1'b0;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLK_48MHZ(clk), .RESET(rst_n),
        .REQ_A(req_a), .WE_A(we_a), .ADDR_A(addr_a), .WDATA_A(wdata_a), .BANK_A(bank_a),
        .ACK_A(ack_a), .RDATA_A(rdata_a),
        .REQ_B(req_b), .WE_B(we_b), .ADDR_B(addr_b), .WDATA_B(wdata_b), .BANK_B(bank_b),
        .ACK_B(ack_b), .RDATA_B(rdata_b),
        .SRAM_CMD(sram_cmd), .SRAM_ADDR(sram_addr), .SRAM_WDATA(sram_wdata), .SRAM_BANK(sram_bank),
        .SRAM_STATUS(sram_status), .SRAM_RDATA(sram_rdata),
        .ARB_BUSY(arb_busy), .GNT_B(gnt_b), .ERR(err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W:0] k);
        return k[DATA_W-1:0] ^ 16'hA5C3 ^ DATA_W'(k[ADDR_W:DATA_W]);
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
    endfunction

    // Controller model: memory contents, busy profile, junk on RDATA when idle
    logic [DATA_W-1:0] ctl_mem [logic [ADDR_W:0]];
    initial begin
        int          cnt;
        logic [ADDR_W:0] key;
        cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cnt = 0;
                sram_status <= 1'b0;
            end else if (ctl_stuck) begin
                sram_status <= 1'b0;
            end else if (sram_cmd != 2'd0) begin
                key = {sram_bank, sram_addr};
                if (sram_cmd == 2'd2) begin
                    ctl_mem[key] = sram_wdata;
                    cnt = 2;
                end else begin
                    sram_rdata <= ctl_mem.exists(key) ? ctl_mem[key] : default_word(key);
                    cnt = 3;
                end
                sram_status <= 1'b0;
            end else if (cnt > 0) begin
                sram_status <= (cnt > 1);
                cnt = cnt - 1;
            end else begin
                sram_rdata <= DATA_W'($urandom);
            end
        end
    end

    // Reference model: transaction-level, using the documented latencies
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W:0]];
    logic [1:0]        e_cmd = 2'd0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_rdata_a = '0, e_rdata_b = '0;
    logic              e_bank = 1'b0, e_ack_a = 1'b0, e_ack_b = 1'b0, e_busy = 1'b0, e_gnt_b = 1'b1;
    initial begin
        bit              busy, last_b, own_b, we;
        int              t, len;
        logic [ADDR_W:0] key;
        logic [DATA_W-1:0] rd;
        busy = 0; last_b = 1; own_b = 0; we = 0; t = 0; len = 0; rd = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 0; last_b = 1;
                e_cmd = 0; e_addr = '0; e_wdata = '0; e_bank = 0; e_ack_a = 0; e_ack_b = 0;
                e_rdata_a = '0; e_rdata_b = '0; e_busy = 0; e_gnt_b = 1;
            end else begin
                e_ack_a = 0; e_ack_b = 0; e_cmd = 0;
                if (!busy) begin
                    if (req_a || req_b) begin
                        if (req_a && req_b) own_b = !last_b;
                        else own_b = req_b;
                        last_b  = own_b;
                        we      = own_b ? we_b : we_a;
                        e_addr  = own_b ? addr_b : addr_a;
                        e_wdata = own_b ? wdata_b : wdata_a;
                        e_bank  = own_b ? bank_b : bank_a;
                        key = {e_bank, e_addr};
                        if (we) ref_mem[key] = e_wdata;
                        else rd = ref_mem.exists(key) ? ref_mem[key] : default_word(key);
                        e_cmd = we ? 2'd2 : 2'd1;
                        e_gnt_b = own_b;
                        e_busy = 1; busy = 1; t = 0;
                        len = we ? 4 : 5;
                    end
                end else begin
                    t++;
                    if (t == len) begin
                        if (own_b) e_ack_b = 1; else e_ack_a = 1;
                        if (!we) begin
                            if (own_b) e_rdata_b = rd; else e_rdata_a = rd;
                        end
                    end else if (t == len + 1) begin
                        busy = 0; e_busy = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_en) begin
            chk_eq("cmd", sram_cmd, e_cmd);
            chk_eq("addr", sram_addr, e_addr);
            chk_eq("wdata", sram_wdata, e_wdata);
            chk_eq("bank", sram_bank, e_bank);
            chk_eq("ack_a", ack_a, e_ack_a);
            chk_eq("ack_b", ack_b, e_ack_b);
            chk_eq("rdata_a", rdata_a, e_rdata_a);
            chk_eq("rdata_b", rdata_b, e_rdata_b);
            chk_eq("arb_busy", arb_busy, e_busy);
            chk_eq("gnt_b", gnt_b, e_gnt_b);
            chk_eq("err", err, 1'b0);
        end
    end

    // Log of issued commands
    logic [31:0] cmd_q[$], gnt_q[$], addr_q[$], wdata_q[$], bank_q[$], edge_q[$];
    always @(negedge clk) begin
        if (sram_cmd != 2'd0) begin
            cmd_q.push_back(32'(sram_cmd));
            gnt_q.push_back(32'(gnt_b));
            addr_q.push_back(32'(sram_addr));
            wdata_q.push_back(32'(sram_wdata));
            bank_q.push_back(32'(sram_bank));
            edge_q.push_back(32'(cyc));
        end
    end

    task automatic xact(input bit side, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit bk);
        int   n;
        logic got;
        if (!side) begin
            we_a = we; addr_a = a; wdata_a = d; bank_a = bk; req_a = 1'b1;
        end else begin
            we_b = we; addr_b = a; wdata_b = d; bank_b = bk; req_b = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = side ? ack_b : ack_a;
        end
        chk_eq(side ? "ack_b_seen" : "ack_a_seen", got, 1'b1);
        if (!side) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic rand_driver(input bit side, input int count);
        int g;
        for (int i = 0; i < count; i++) begin
            g = $urandom_range(0, 3);
            repeat (g) @(negedge clk);
            xact(side, 1'($urandom_range(0, 1)), rand_addr(), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int base, n;
        ctl_mem[{1'b1, 18'h3FFFF}] = 16'h1234;
        ref_mem[{1'b1, 18'h3FFFF}] = 16'h1234;

        // Reset values
        repeat (3) @(negedge clk);
        chk_eq("rst_cmd", sram_cmd, 2'd0);
        chk_eq("rst_busy", arb_busy, 1'b0);
        chk_eq("rst_gnt_b", gnt_b, 1'b1);
        chk_eq("rst_ack_a", ack_a, 1'b0);
        chk_eq("rst_rdata_b", rdata_b, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A write
        base = cmd_q.size();
        xact(1'b0, 1'b1, 18'h00010, 16'hBEEF, 1'b0);
        chk_eq("t1_cmd_cycles", cmd_q.size() - base, 1);
        if (cmd_q.size() > base) begin
            chk_eq("t1_cmd", cmd_q[base], 2);
            chk_eq("t1_addr", addr_q[base], 32'h10);
            chk_eq("t1_wdata", wdata_q[base], 32'hBEEF);
        end
        chk_eq("t1_rdata_a", rdata_a, '0);

        // Single B read from the top address, high bank
        base = cmd_q.size();
        xact(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 1'b1);
        chk_eq("t2_cmd_cycles", cmd_q.size() - base, 1);
        if (cmd_q.size() > base) begin
            chk_eq("t2_cmd", cmd_q[base], 1);
            chk_eq("t2_bank", bank_q[base], 1);
        end
        chk_eq("t2_rdata_b", rdata_b, 16'h1234);
        chk_eq("t2_rdata_a", rdata_a, '0);

        // Simultaneous held requests: A write, B read
        base = cmd_q.size();
        we_a = 1'b1; addr_a = 18'h00021; wdata_a = 16'hC0DE; bank_a = 1'b0;
        we_b = 1'b0; addr_b = 18'h00021; wdata_b = 16'h0000; bank_b = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        n = 0;
        while (cmd_q.size() < base + 4 && n < 100) begin @(negedge clk); #1; n++; end
        chk_eq("t3_grant_count", cmd_q.size() - base, 4);
        req_a = 1'b0;
        n = 0;
        while (!ack_b && n < 20) begin @(negedge clk); #1; n++; end
        chk_eq("t3_last_ack_b", ack_b, 1'b1);
        req_b = 1'b0;
        if (cmd_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) chk_eq("t3_gnt_order", gnt_q[base + i], i % 2);
            chk_eq("t3_cmd_a", cmd_q[base], 2);
            chk_eq("t3_cmd_b", cmd_q[base + 1], 1);
            chk_eq("t3_gap_wr", edge_q[base + 1] - edge_q[base], 6);
            chk_eq("t3_gap_rd", edge_q[base + 2] - edge_q[base + 1], 7);
            chk_eq("t3_gap_wr2", edge_q[base + 3] - edge_q[base + 2], 6);
        end
        chk_eq("t3_rdata_b", rdata_b, 16'hC0DE);

        // REQ_A held through ACK: back-to-back identical writes
        base = cmd_q.size();
        we_a = 1'b1; addr_a = 18'h00155; wdata_a = 16'h5A5A; bank_a = 1'b0; req_a = 1'b1;
        n = 0;
        while (cmd_q.size() < base + 2 && n < 40) begin @(negedge clk); #1; n++; end
        chk_eq("t5_issue_count", cmd_q.size() - base, 2);
        n = 0;
        while (!ack_a && n < 20) begin @(negedge clk); #1; n++; end
        chk_eq("t5_ack_a", ack_a, 1'b1);
        req_a = 1'b0;
        if (cmd_q.size() >= base + 2) begin
            chk_eq("t5_gap", edge_q[base + 1] - edge_q[base], 6);
            chk_eq("t5_addr2", addr_q[base + 1], 32'h155);
            chk_eq("t5_wdata2", wdata_q[base + 1], 32'h5A5A);
        end

        // Reset while the read sits in WAIT_DONE
        @(negedge clk);
        base = cmd_q.size();
        we_b = 1'b0; addr_b = 18'h0002A; bank_b = 1'b0; req_b = 1'b1;
        n = 0;
        while (cmd_q.size() == base && n < 20) begin @(negedge clk); #1; n++; end
        chk_eq("t4_issued", cmd_q.size() - base, 1);
        repeat (3) @(negedge clk);
        chk_eq("t4_busy_before", arb_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        req_b = 1'b0;
        #1;
        chk_eq("t4_cmd", sram_cmd, 2'd0);
        chk_eq("t4_busy", arb_busy, 1'b0);
        chk_eq("t4_ack_b", ack_b, 1'b0);
        chk_eq("t4_gnt_b", gnt_b, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 1'b0, 18'h0002A, 16'h0000, 1'b0);
        chk_eq("t4_fresh_rdata_a", rdata_a, default_word({1'b0, 18'h0002A}));

        // Randomized concurrent traffic
        fork
            rand_driver(1'b0, 25);
            rand_driver(1'b1, 25);
        join
        repeat (3) @(negedge clk);

        // Controller stuck idle
        m_en = 1'b0;
        ctl_stuck = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        base = cmd_q.size();
        we_a = 1'b1; addr_a = 18'h00077; wdata_a = 16'h7777; bank_a = 1'b0; req_a = 1'b1;
        n = 0;
        while (cmd_q.size() == base && n < 20) begin @(negedge clk); #1; n++; end
        chk_eq("stuck_issued", cmd_q.size() - base, 1);
`ifdef SRAM_ARB_WATCHDOG_EN
        begin
            int err_at, ack_at, err_cnt;
            err_at = -1; ack_at = -1; err_cnt = 0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk); #1;
                if (err) err_cnt++;
                if (err && err_at < 0) err_at = k;
                if (ack_a && ack_at < 0) begin ack_at = k; req_a = 1'b0; end
            end
            chk_eq("wd_err_cycle", err_at, 16);
            chk_eq("wd_ack_cycle", ack_at, 16);
            chk_eq("wd_err_pulses", err_cnt, 1);
            chk_eq("wd_busy_after", arb_busy, 1'b0);
        end
`else
        begin
            int ack_cnt;
            ack_cnt = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk); #1;
                if (ack_a) ack_cnt++;
            end
            chk_eq("nowd_ack", ack_cnt, 0);
            chk_eq("nowd_busy", arb_busy, 1'b1);
            chk_eq("nowd_err", err, 1'b0);
        end
`endif
        req_a = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
